basys3_uart_tx_sched: RTL and testbench
=======================================

# basys3_uart_tx_sched

Round-robin scheduler that shares one UART transmit serializer between NREQ byte requesters on the Basys3 link. Each granted request is sent as a three-byte packet (header, payload, checksum) so the Basys3 side can demultiplex channels. Sits between the requester logic and the UART TX serializer inside the top-level tile; the serializer and the pin muxing stay outside this block.

## Interface
- NREQ, 4, number of requesters (2..4; header carries a 2-bit id)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  requester i has a byte pending; held until req_ready[i]
- req_data  in  NREQ*8  byte of requester i at bits [8i+7:8i]
- req_ready  out  NREQ  one-cycle pulse: byte of requester i captured
- tx_data  out  8  byte to serializer, valid while tx_start high
- tx_start  out  1  one-cycle pulse: serializer loads tx_data
- tx_busy  in  1  serializer busy; high from cycle after tx_start until stop bit done
- grant_id  out  2  id of the packet in flight (0 when idle)
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, HDR, WAIT_HDR, DAT, WAIT_DAT, CHK, WAIT_CHK.
- IDLE: if any req_valid, pick winner by round-robin starting at last_grant+1 mod NREQ; capture req_data of winner into data_q, set grant_id, pulse req_ready[winner], -> HDR. last_grant updated to winner.
- HDR: tx_start=1, tx_data = {4'hA, 2'b00, grant_id} -> WAIT_HDR.
- DAT: tx_start=1, tx_data = data_q -> WAIT_DAT.
- CHK: tx_start=1, tx_data = header XOR data_q -> WAIT_CHK.
- WAIT_x: tx_busy ignored in first cycle of the state; from second cycle, exit on tx_busy==0 (WAIT_HDR->DAT, WAIT_DAT->CHK, WAIT_CHK->IDLE).
- req_valid sampled only in IDLE; a requester dropping valid before grant is simply not served. No requests accepted mid-packet.
- tx_data is 0 whenever tx_start is low.

## Timing
- Reset values: state IDLE, req_ready 0, tx_start 0, tx_data 0, grant_id 0, busy 0, data_q 0, last_grant NREQ-1 (first search starts at id 0).
- All outputs registered or decoded directly from the state register; no input-to-output combinational path.
- Grant edge at cycle k: req_ready[i] and busy high in cycle k+1 (state HDR), tx_start header in k+1.
- Minimum packet: 3 tx_start pulses, each followed by ≥2 WAIT cycles; back-to-back packets need one IDLE cycle between WAIT_CHK exit and next HDR.
- Simultaneous valid on all channels: exactly one granted per IDLE visit; starvation bound NREQ-1 packets.
- rst_n assertion mid-packet: all outputs to reset values immediately (asynchronous); partial packet abandoned, no req_ready for lost byte; after release scheduler resumes from id 0.

## Structure
- Shared package basys3_uart_pkg: state enum sched_state_t, HDR_MAGIC = 4'hA, MAX_NREQ = 4.
- One sub-module: rr_arbiter (NREQ-wide request vector, last_grant in, one-hot grant + encoded id out, combinational).
- FSM, data_q, last_grant register in the top of this block.

## Test plan
- Single request ch2 data 0x5C, serializer model busy 10 cycles per byte -> tx bytes 0xA2, 0x5C, 0xFE; req_ready[2] one pulse; busy low after WAIT_CHK.
- All four valid from reset, data 0x10..0x13 -> packets in id order 0,1,2,3; headers 0xA0..0xA3, checksums 0xB0 each.
- ch1 and ch3 continuously valid -> grants alternate 1,3,1,3 over 6 packets; ch0/ch2 never pulse ready.
- tx_busy held high 100 cycles after header -> no second tx_start until cycle after tx_busy falls.
- rst_n low during WAIT_DAT -> tx_start, busy, grant_id 0 same cycle; after release, pending ch0 request gets header 0xA0.
- ch1 valid raised then dropped while ch0 packet in flight -> only ch0 packet sent, req_ready[1] never asserted.

Source files
------------

// File: rtl/basys3_uart_pkg.sv
// rtl/basys3_uart_pkg.sv - shared types and constants for the Basys3 UART TX scheduler
// Purpose: scheduler state encoding, packet header magic and header builder.
// Ports: none (package).
package basys3_uart_pkg;

  localparam logic [3:0] HDR_MAGIC = 4'hA;
  localparam int         MAX_NREQ  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WAIT_HDR,
    S_DAT,
    S_WAIT_DAT,
    S_CHK,
    S_WAIT_CHK
  } sched_state_t;

  // Header byte: magic nibble, two reserved zero bits, 2-bit channel id.
  function automatic logic [7:0] hdr_byte(input logic [1:0] id);
    return {HDR_MAGIC, 2'b00, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Purpose: pick the first requester at or after last_grant+1 (mod NREQ).
// Ports:
//   req        in  NREQ  request vector
//   last_grant in  2     id granted most recently
//   grant      out NREQ  one-hot winner (all zero when no request)
//   id         out 2     encoded winner id
//   any        out 1     at least one request present
module rr_arbiter
  import basys3_uart_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last_grant,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      id,
  output logic            any
);

  localparam int IDW = (NREQ > 2) ? 2 : 1;

  int             idx;
  logic [IDW-1:0] idx_l;

  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    idx   = 0;
    idx_l = '0;
    // Walk the ring starting one past the previous winner; first hit wins.
    for (int off = 1; off <= NREQ; off++) begin
      idx   = (int'(last_grant) + off) % NREQ;
      idx_l = IDW'(idx);
      if (!any && req[idx_l]) begin
        any          = 1'b1;
        grant[idx_l] = 1'b1;
        id           = 2'(idx);
      end
    end
  end

endmodule

// File: rtl/basys3_uart_tx_sched.sv
// rtl/basys3_uart_tx_sched.sv - round-robin scheduler sharing one UART TX serializer
// Purpose: grants one requester per IDLE visit and sends header, payload, checksum.
// Ports:
//   clk, rst_n  in        clock, asynchronous active-low reset
//   req_valid   in  NREQ  requester byte pending
//   req_data    in  8*NREQ requester bytes, channel i at [8i+7:8i]
//   req_ready   out NREQ  one-cycle capture pulse
//   tx_data     out 8     byte to serializer (0 when tx_start low)
//   tx_start    out 1     serializer load pulse
//   tx_busy     in  1     serializer busy
//   grant_id    out 2     channel of packet in flight (0 when idle)
//   busy        out 1     scheduler not idle
module basys3_uart_tx_sched
  import basys3_uart_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [1:0]        grant_id,
  output logic              busy
);

  sched_state_t    state_q, state_d;
  logic [7:0]      data_q;
  logic [1:0]      last_grant_q;
  logic [1:0]      grant_id_q;
  logic [NREQ-1:0] req_ready_q;
  logic            wait_first_q;

  logic [NREQ-1:0] arb_grant;
  logic [1:0]      arb_id;
  logic            arb_any;
  logic [7:0]      win_data;
  logic [7:0]      header;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .id         (arb_id),
    .any        (arb_any)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) win_data = req_data[8*i +: 8];
    end
  end

  assign header    = hdr_byte(grant_id_q);
  assign req_ready = req_ready_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // WAIT states ignore tx_busy in their first cycle: the serializer only
  // raises busy the cycle after tx_start, so that cycle carries no information.
  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    unique case (state_q)
      S_IDLE:     if (arb_any) state_d = S_HDR;
      S_HDR: begin
        tx_start = 1'b1;
        tx_data  = header;
        state_d  = S_WAIT_HDR;
      end
      S_WAIT_HDR: if (!wait_first_q && !tx_busy) state_d = S_DAT;
      S_DAT: begin
        tx_start = 1'b1;
        tx_data  = data_q;
        state_d  = S_WAIT_DAT;
      end
      S_WAIT_DAT: if (!wait_first_q && !tx_busy) state_d = S_CHK;
      S_CHK: begin
        tx_start = 1'b1;
        tx_data  = header ^ data_q;
        state_d  = S_WAIT_CHK;
      end
      S_WAIT_CHK: if (!wait_first_q && !tx_busy) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      last_grant_q <= 2'(NREQ - 1);
      grant_id_q   <= '0;
      req_ready_q  <= '0;
      wait_first_q <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      wait_first_q <= (state_q == S_HDR) || (state_q == S_DAT) || (state_q == S_CHK);
      if (state_q == S_IDLE && arb_any) begin
        data_q       <= win_data;
        grant_id_q   <= arb_id;
        last_grant_q <= arb_id;
        req_ready_q  <= arb_grant;
      end else if (state_q == S_WAIT_CHK && state_d == S_IDLE) begin
        grant_id_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_basys3_uart_tx_sched.sv
// tb/tb_basys3_uart_tx_sched.sv - scoreboard bench for basys3_uart_tx_sched
module tb_basys3_uart_tx_sched;

  localparam int NREQ = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [1:0]        grant_id;
  logic              busy;

  basys3_uart_tx_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] exp_tx[$];
  int         exp_rdy[$];
  logic [7:0] chq[NREQ][$];

  logic [NREQ-1:0] rdy_seen;
  logic            start_seen;
  int              busy_len;
  int              busy_cnt;
  int              prev_start;
  int              mon_id;
  logic [7:0]      mon_byte;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic exp_pkt(input int id, input logic [7:0] h, input logic [7:0] d, input logic [7:0] c);
    exp_rdy.push_back(id);
    exp_tx.push_back(h);
    exp_tx.push_back(d);
    exp_tx.push_back(c);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_rdy.size() != 0 || busy) && n < 3000) begin
      step();
      n++;
    end
    chk({name, "_drained"}, {31'd0, (exp_tx.size() == 0 && exp_rdy.size() == 0 && !busy)}, 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Serializer model: busy for busy_len cycles starting the cycle after tx_start.
  initial begin
    tx_busy  = 1'b0;
    busy_cnt = 0;
  end
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      busy_cnt = 0;
      tx_busy  = 1'b0;
    end else if (start_seen) begin
      busy_cnt = busy_len;
      tx_busy  = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      tx_busy  = (busy_cnt > 0);
    end
  end

  // Requester model: each channel presents the head of its queue, pops on ready.
  initial begin
    req_valid = '0;
    req_data  = '0;
  end
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (rdy_seen[i] && chq[i].size() > 0) void'(chq[i].pop_front());
    end
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]      = (chq[i].size() > 0);
      req_data[8*i +: 8] = (chq[i].size() > 0) ? chq[i][0] : 8'h00;
    end
  end

  // Monitor: compares every DUT output event against the scoreboard queues.
  initial begin
    rdy_seen   = '0;
    start_seen = 1'b0;
    prev_start = 0;
  end
  always @(negedge clk) begin
    rdy_seen   = req_ready;
    start_seen = tx_start;
    if (rst_n) begin
      if (req_ready != '0) begin
        if (exp_rdy.size() == 0) begin
          chk("unexpected_ready", {28'd0, req_ready}, 32'd0);
        end else begin
          mon_id = exp_rdy.pop_front();
          chk("ready_onehot", {28'd0, req_ready}, 32'd1 << mon_id);
          chk("grant_id", {30'd0, grant_id}, mon_id);
        end
      end
      if (tx_start) begin
        if (exp_tx.size() == 0) begin
          chk("unexpected_tx_start", {31'd0, tx_start}, 32'd0);
        end else begin
          mon_byte = exp_tx.pop_front();
          chk("tx_byte", {24'd0, tx_data}, {24'd0, mon_byte});
        end
        if (req_ready == '0) chk("start_gap", cyc - prev_start, busy_len + 2);
        prev_start = cyc;
      end else begin
        chk("tx_data_zero", {24'd0, tx_data}, 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    busy_len = 10;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();

    // All four valid from reset: ids 0..3 in order, checksum 0xB0 each.
    exp_pkt(0, 8'hA0, 8'h10, 8'hB0);
    exp_pkt(1, 8'hA1, 8'h11, 8'hB0);
    exp_pkt(2, 8'hA2, 8'h12, 8'hB0);
    exp_pkt(3, 8'hA3, 8'h13, 8'hB0);
    for (int i = 0; i < NREQ; i++) chq[i].push_back(8'h10 + 8'(i));
    drain("all4");

    // ch1 and ch3 continuously valid: grants alternate 1,3,1,3,1,3.
    exp_pkt(1, 8'hA1, 8'h21, 8'h80);
    exp_pkt(3, 8'hA3, 8'h31, 8'h92);
    exp_pkt(1, 8'hA1, 8'h22, 8'h83);
    exp_pkt(3, 8'hA3, 8'h32, 8'h91);
    exp_pkt(1, 8'hA1, 8'h23, 8'h82);
    exp_pkt(3, 8'hA3, 8'h33, 8'h90);
    chq[1].push_back(8'h21); chq[1].push_back(8'h22); chq[1].push_back(8'h23);
    chq[3].push_back(8'h31); chq[3].push_back(8'h32); chq[3].push_back(8'h33);
    drain("alt13");

    // Single request on ch2.
    exp_pkt(2, 8'hA2, 8'h5C, 8'hFE);
    chq[2].push_back(8'h5C);
    drain("single_ch2");
    chk("single_busy_low", {31'd0, busy}, 32'd0);
    chk("single_grant_id_idle", {30'd0, grant_id}, 32'd0);

    // Long serializer busy: next tx_start only the cycle after busy falls.
    busy_len = 100;
    exp_pkt(0, 8'hA0, 8'h44, 8'hE4);
    chq[0].push_back(8'h44);
    drain("long_busy");
    busy_len = 10;

    // ch1 raised then dropped while ch0 packet in flight: never served.
    exp_pkt(0, 8'hA0, 8'h66, 8'hC6);
    chq[0].push_back(8'h66);
    n = 0;
    while (exp_tx.size() > 2 && n < 500) begin step(); n++; end
    chk("drop_hdr_seen", {31'd0, exp_tx.size() <= 2}, 32'd1);
    chq[1].push_back(8'h77);
    repeat (5) step();
    chq[1].delete();
    drain("drop_ch1");
    repeat (30) step();

    // Reset during WAIT_DAT, then pending ch0 must win before ch1.
    exp_rdy.push_back(0);
    exp_tx.push_back(8'hA0);
    exp_tx.push_back(8'h55);
    chq[0].push_back(8'h55);
    n = 0;
    while (exp_tx.size() != 0 && n < 500) begin step(); n++; end
    chk("rst_mid_data_seen", {31'd0, exp_tx.size() == 0}, 32'd1);
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    chq[0].push_back(8'h99);
    chq[1].push_back(8'h88);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_grant_id", {30'd0, grant_id}, 32'd0);
    chk("rst_mid_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_mid_tx_data", {24'd0, tx_data}, 32'd0);
    exp_pkt(0, 8'hA0, 8'h99, 8'h39);
    exp_pkt(1, 8'hA1, 8'h88, 8'h29);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    drain("after_reset");
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
